// File: rtl/jump_sequencer.sv
// Handshaked sequencer for RV32I JAL/JALR: decodes the immediate, forms target and link,
// checks target alignment, then issues a single registered register-file / PC write.
module jump_sequencer #(
    parameter int XLEN        = 32,
    parameter int CHECK_ALIGN = 1,
    parameter int RET_OFFSET  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            insn_valid,
    output logic            insn_ready,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            pc_we,
    output logic [XLEN-1:0] pc_next,
    output logic            done,
    output logic            misaligned,
    output logic            unsupported
);

    localparam logic [XLEN-1:0] RET_OFF = XLEN'(RET_OFFSET);
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_CALC,
        S_WB,
        S_TRAP
    } state_t;

    state_t          state_reg;
    logic [31:0]     insn_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] rs1_val_reg;
    logic [XLEN-1:0] imm_reg;
    logic            is_jalr_reg;
    logic            insn_ready_reg;
    logic            rd_we_reg;
    logic            pc_we_reg;
    logic            done_reg;
    logic            misaligned_reg;
    logic            unsupported_reg;
    logic [XLEN-1:0] rd_wdata_reg;
    logic [XLEN-1:0] pc_next_reg;

    logic            is_jal_next;
    logic            is_jalr_next;
    logic [XLEN-1:0] imm_j_next;
    logic [XLEN-1:0] imm_i_next;
    logic [XLEN-1:0] sum_next;
    logic [XLEN-1:0] target_next;
    logic [XLEN-1:0] link_next;
    logic            misalign_next;

    always_comb begin
        is_jal_next   = (insn_reg[6:0] == OP_JAL);
        is_jalr_next  = (insn_reg[6:0] == OP_JALR) && (insn_reg[14:12] == 3'b000);
        imm_j_next    = {{(XLEN-20){insn_reg[31]}}, insn_reg[19:12], insn_reg[20],
                         insn_reg[30:21], 1'b0};
        imm_i_next    = {{(XLEN-12){insn_reg[31]}}, insn_reg[31:20]};
        sum_next      = (is_jalr_reg ? rs1_val_reg : pc_reg) + imm_reg;
        // JALR clears bit 0 of the sum; JAL targets are even by construction
        target_next   = is_jalr_reg ? {sum_next[XLEN-1:1], 1'b0} : sum_next;
        link_next     = pc_reg + RET_OFF;
        misalign_next = (CHECK_ALIGN != 0) && target_next[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            insn_reg        <= '0;
            pc_reg          <= '0;
            rs1_val_reg     <= '0;
            imm_reg         <= '0;
            is_jalr_reg     <= 1'b0;
            insn_ready_reg  <= 1'b1;
            rd_we_reg       <= 1'b0;
            pc_we_reg       <= 1'b0;
            done_reg        <= 1'b0;
            misaligned_reg  <= 1'b0;
            unsupported_reg <= 1'b0;
            rd_wdata_reg    <= '0;
            pc_next_reg     <= '0;
        end else begin
            rd_we_reg       <= 1'b0;
            pc_we_reg       <= 1'b0;
            done_reg        <= 1'b0;
            misaligned_reg  <= 1'b0;
            unsupported_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (insn_valid) begin
                        insn_reg       <= insn;
                        pc_reg         <= pc;
                        insn_ready_reg <= 1'b0;
                        state_reg      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs1_val_reg <= rs1_data;
                    is_jalr_reg <= is_jalr_next;
                    imm_reg     <= is_jalr_next ? imm_i_next : imm_j_next;
                    if (is_jal_next || is_jalr_next) begin
                        state_reg <= S_CALC;
                    end else begin
                        unsupported_reg <= 1'b1;
                        state_reg       <= S_TRAP;
                    end
                end
                S_CALC: begin
                    pc_next_reg  <= target_next;
                    rd_wdata_reg <= link_next;
                    if (misalign_next) begin
                        misaligned_reg <= 1'b1;
                        state_reg      <= S_TRAP;
                    end else begin
                        pc_we_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        rd_we_reg <= (insn_reg[11:7] != 5'd0);
                        state_reg <= S_WB;
                    end
                end
                S_WB, S_TRAP: begin
                    insn_ready_reg <= 1'b1;
                    state_reg      <= S_IDLE;
                end
                default: begin
                    insn_ready_reg <= 1'b1;
                    state_reg      <= S_IDLE;
                end
            endcase
        end
    end

    assign insn_ready  = insn_ready_reg;
    assign rs1_addr    = insn_reg[19:15];
    assign rd_addr     = insn_reg[11:7];
    assign rd_we       = rd_we_reg;
    assign rd_wdata    = rd_wdata_reg;
    assign pc_we       = pc_we_reg;
    assign pc_next     = pc_next_reg;
    assign done        = done_reg;
    assign misaligned  = misaligned_reg;
    assign unsupported = unsupported_reg;

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed bench for jump_sequencer: one instance with alignment checking, one without,
// driven in lockstep; expected results are queued at issue and popped on each retire pulse.
module tb_jump_sequencer;

    typedef struct packed {
        logic        done;
        logic        mis;
        logic        uns;
        logic        rd_we;
        logic        pc_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_next;
        logic [3:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rs1_data;

    logic        insn_ready_a, rd_we_a, pc_we_a, done_a, misaligned_a, unsupported_a;
    logic [4:0]  rs1_addr_a, rd_addr_a;
    logic [31:0] rd_wdata_a, pc_next_a;
    logic        insn_ready_b, rd_we_b, pc_we_b, done_b, misaligned_b, unsupported_b;
    logic [4:0]  rs1_addr_b, rd_addr_b;
    logic [31:0] rd_wdata_b, pc_next_b;

    int compared   = 0;
    int mismatched = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    jump_sequencer #(.XLEN(32), .CHECK_ALIGN(1), .RET_OFFSET(4)) dut_a (
        .clk(clk), .reset(reset), .insn_valid(insn_valid), .insn_ready(insn_ready_a),
        .insn(insn), .pc(pc), .rs1_addr(rs1_addr_a), .rs1_data(rs1_data),
        .rd_we(rd_we_a), .rd_addr(rd_addr_a), .rd_wdata(rd_wdata_a),
        .pc_we(pc_we_a), .pc_next(pc_next_a), .done(done_a),
        .misaligned(misaligned_a), .unsupported(unsupported_a)
    );

    jump_sequencer #(.XLEN(32), .CHECK_ALIGN(0), .RET_OFFSET(4)) dut_b (
        .clk(clk), .reset(reset), .insn_valid(insn_valid), .insn_ready(insn_ready_b),
        .insn(insn), .pc(pc), .rs1_addr(rs1_addr_b), .rs1_data(rs1_data),
        .rd_we(rd_we_b), .rd_addr(rd_addr_b), .rd_wdata(rd_wdata_b),
        .pc_we(pc_we_b), .pc_next(pc_next_b), .done(done_b),
        .misaligned(misaligned_b), .unsupported(unsupported_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic d, input logic m, input logic u, input logic rw,
                                input logic pw, input logic [4:0] ra, input logic [31:0] wd,
                                input logic [31:0] pn, input logic [3:0] lat);
        exp_t e;
        e = '{done: d, mis: m, uns: u, rd_we: rw, pc_we: pw, rd_addr: ra,
              rd_wdata: wd, pc_next: pn, lat: lat};
        return e;
    endfunction

    task automatic cmp_a(input string tag);
        exp_t e;
        if (q_a.size() == 0) begin
            check({tag, ".a.queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = q_a.pop_front();
            check({tag, ".a.done"}, 32'(done_a), 32'(e.done));
            check({tag, ".a.misaligned"}, 32'(misaligned_a), 32'(e.mis));
            check({tag, ".a.unsupported"}, 32'(unsupported_a), 32'(e.uns));
            check({tag, ".a.rd_we"}, 32'(rd_we_a), 32'(e.rd_we));
            check({tag, ".a.pc_we"}, 32'(pc_we_a), 32'(e.pc_we));
            check({tag, ".a.rd_addr"}, 32'(rd_addr_a), 32'(e.rd_addr));
            check({tag, ".a.rd_wdata"}, rd_wdata_a, e.rd_wdata);
            check({tag, ".a.pc_next"}, pc_next_a, e.pc_next);
        end
    endtask

    task automatic cmp_b(input string tag);
        exp_t e;
        if (q_b.size() == 0) begin
            check({tag, ".b.queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = q_b.pop_front();
            check({tag, ".b.done"}, 32'(done_b), 32'(e.done));
            check({tag, ".b.misaligned"}, 32'(misaligned_b), 32'(e.mis));
            check({tag, ".b.unsupported"}, 32'(unsupported_b), 32'(e.uns));
            check({tag, ".b.rd_we"}, 32'(rd_we_b), 32'(e.rd_we));
            check({tag, ".b.pc_we"}, 32'(pc_we_b), 32'(e.pc_we));
            check({tag, ".b.rd_addr"}, 32'(rd_addr_b), 32'(e.rd_addr));
            check({tag, ".b.rd_wdata"}, rd_wdata_b, e.rd_wdata);
            check({tag, ".b.pc_next"}, pc_next_b, e.pc_next);
        end
    endtask

    // Present one instruction for a single accepting edge, then scramble insn/pc.
    task automatic offer(input string tag, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r);
        @(negedge clk);
        check({tag, ".ready_before"}, 32'(insn_ready_a), 32'd1);
        insn = i;
        pc = p;
        rs1_data = r;
        insn_valid = 1'b1;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        insn = $urandom;
        pc = $urandom;
    endtask

    // Wait for the retire/trap pulse, check latency and outputs, then the return to IDLE.
    task automatic expect_result(input string tag);
        int  n;
        bit  seen;
        logic [3:0] lat;
        n = 0;
        seen = 1'b0;
        lat = (q_a.size() != 0) ? q_a[0].lat : 4'd0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (done_a || misaligned_a || unsupported_a) seen = 1'b1;
        end
        check({tag, ".pulse_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, ".latency"}, 32'(n), 32'(lat));
            cmp_a(tag);
            cmp_b(tag);
            @(negedge clk);
            check({tag, ".one_cycle"}, 32'(done_a | misaligned_a | unsupported_a | pc_we_a | rd_we_a), 32'd0);
            check({tag, ".ready_after"}, 32'(insn_ready_a), 32'd1);
        end
    endtask

    logic [31:0] b2b_pc   [3];
    logic [31:0] b2b_link [3];
    logic [31:0] b2b_tgt  [3];

    initial begin
        int k;
        int pulses;
        int last;
        int strobes;

        b2b_pc   = '{32'h300, 32'h400, 32'h500};
        b2b_link = '{32'h304, 32'h404, 32'h504};
        b2b_tgt  = '{32'h308, 32'h408, 32'h508};

        reset = 1'b1;
        insn_valid = 1'b0;
        insn = '0;
        pc = '0;
        rs1_data = '0;
        repeat (3) @(negedge clk);
        check("reset.rd_we", 32'(rd_we_a), 32'd0);
        check("reset.pc_we", 32'(pc_we_a), 32'd0);
        check("reset.pulses", 32'(done_a | misaligned_a | unsupported_a), 32'd0);
        check("reset.rd_addr", 32'(rd_addr_a), 32'd0);
        check("reset.rs1_addr", 32'(rs1_addr_a), 32'd0);
        check("reset.rd_wdata", rd_wdata_a, 32'd0);
        check("reset.pc_next", pc_next_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset.ready_after", 32'(insn_ready_a), 32'd1);

        // JAL x1,+8 at 0x100
        q_a.push_back(mk(1, 0, 0, 1, 1, 5'd1, 32'h104, 32'h108, 4'd3));
        q_b.push_back(mk(1, 0, 0, 1, 1, 5'd1, 32'h104, 32'h108, 4'd3));
        offer("jal_x1", 32'h008000EF, 32'h100, 32'h0);
        expect_result("jal_x1");

        // JALR x5,-4(x2), rs1=0x1003: target 0xFFE traps only when alignment is checked
        q_a.push_back(mk(0, 1, 0, 0, 0, 5'd5, 32'h204, 32'hFFE, 4'd3));
        q_b.push_back(mk(1, 0, 0, 1, 1, 5'd5, 32'h204, 32'hFFE, 4'd3));
        offer("jalr_x5", 32'hFFC102E7, 32'h200, 32'h1003);
        check("jalr_x5.rs1_addr", 32'(rs1_addr_a), 32'd2);
        expect_result("jalr_x5");

        // JAL x0,-16 at 0: wraps, no register write
        q_a.push_back(mk(1, 0, 0, 0, 1, 5'd0, 32'h4, 32'hFFFFFFF0, 4'd3));
        q_b.push_back(mk(1, 0, 0, 0, 1, 5'd0, 32'h4, 32'hFFFFFFF0, 4'd3));
        offer("jal_x0", 32'hFF1FF06F, 32'h0, 32'h0);
        expect_result("jal_x0");

        // ADDI x1,x0,1: unsupported, data outputs hold their previous values
        q_a.push_back(mk(0, 0, 1, 0, 0, 5'd1, 32'h4, 32'hFFFFFFF0, 4'd2));
        q_b.push_back(mk(0, 0, 1, 0, 0, 5'd1, 32'h4, 32'hFFFFFFF0, 4'd2));
        offer("addi", 32'h00100093, 32'h40, 32'h0);
        expect_result("addi");

        // insn_valid held high across three JALs
        k = 0;
        pulses = 0;
        last = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done_a) begin
                pulses++;
                cmp_a($sformatf("b2b%0d", pulses));
                cmp_b($sformatf("b2b%0d", pulses));
                if (last >= 0) check("b2b.spacing", 32'(t - last), 32'd4);
                last = t;
            end
            if (insn_ready_a) begin
                if (k < 3) begin
                    insn = 32'h008000EF;
                    pc = b2b_pc[k];
                    insn_valid = 1'b1;
                    q_a.push_back(mk(1, 0, 0, 1, 1, 5'd1, b2b_link[k], b2b_tgt[k], 4'd3));
                    q_b.push_back(mk(1, 0, 0, 1, 1, 5'd1, b2b_link[k], b2b_tgt[k], 4'd3));
                    k++;
                end else begin
                    insn_valid = 1'b0;
                end
            end
        end
        check("b2b.pulse_count", 32'(pulses), 32'd3);
        check("b2b.queue_drained", 32'(q_a.size()), 32'd0);

        // Reset while in CALC: nothing may be written
        offer("rst_calc", 32'h008000EF, 32'h100, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_calc.rd_we", 32'(rd_we_a), 32'd0);
        check("rst_calc.pc_we", 32'(pc_we_a), 32'd0);
        check("rst_calc.done", 32'(done_a), 32'd0);
        check("rst_calc.rd_addr", 32'(rd_addr_a), 32'd0);
        check("rst_calc.rd_wdata", rd_wdata_a, 32'd0);
        check("rst_calc.pc_next", pc_next_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (rd_we_a || pc_we_a || done_a || rd_we_b || pc_we_b || done_b) strobes++;
        end
        check("rst_calc.no_strobes", 32'(strobes), 32'd0);
        check("rst_calc.ready", 32'(insn_ready_a), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
